// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for the shared 6-bit external memory port.
// One access in flight at a time; read data is sampled a fixed LAT cycles after the address is driven.
module mem_port_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 6,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              busy,
    output logic              owner
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LAT);

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic [3:0]        cnt_nxt;
    logic              owner_r;
    logic              owner_nxt;
    logic              last_grant;
    logic              last_grant_nxt;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] rdata0_r;
    logic [DATA_W-1:0] rdata0_nxt;
    logic [DATA_W-1:0] rdata1_r;
    logic [DATA_W-1:0] rdata1_nxt;
    logic              rvalid0_r;
    logic              rvalid0_nxt;
    logic              rvalid1_r;
    logic              rvalid1_nxt;
    logic              grant_any;
    logic              grant_idx;

    // Contested requests go to whoever did not win last time.
    function automatic logic pick(input logic r0, input logic r1, input logic last);
        if (r0 && r1) begin
            return ~last;
        end
        return r1;
    endfunction

    assign grant_any = req0 | req1;
    assign grant_idx = pick(req0, req1, last_grant);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            owner_r    <= 1'b0;
            last_grant <= 1'b1;
            mem_addr_r <= '0;
            rdata0_r   <= '0;
            rdata1_r   <= '0;
            rvalid0_r  <= 1'b0;
            rvalid1_r  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            owner_r    <= owner_nxt;
            last_grant <= last_grant_nxt;
            mem_addr_r <= mem_addr_nxt;
            rdata0_r   <= rdata0_nxt;
            rdata1_r   <= rdata1_nxt;
            rvalid0_r  <= rvalid0_nxt;
            rvalid1_r  <= rvalid1_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        owner_nxt      = owner_r;
        last_grant_nxt = last_grant;
        mem_addr_nxt   = mem_addr_r;
        rdata0_nxt     = rdata0_r;
        rdata1_nxt     = rdata1_r;
        rvalid0_nxt    = 1'b0;
        rvalid1_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    state_nxt      = WAIT;
                    cnt_nxt        = CNT_INIT;
                    owner_nxt      = grant_idx;
                    last_grant_nxt = grant_idx;
                    mem_addr_nxt   = grant_idx ? addr1 : addr0;
                end
            end
            WAIT: begin
                // cnt==1 marks the cycle whose closing edge samples the pins.
                if (cnt == 4'd1) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                    if (owner_r) begin
                        rdata1_nxt  = mem_data;
                        rvalid1_nxt = 1'b1;
                    end else begin
                        rdata0_nxt  = mem_data;
                        rvalid0_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        busy     = (state == WAIT);
        gnt0     = (state == WAIT) && !owner_r;
        gnt1     = (state == WAIT) && owner_r;
        owner    = owner_r;
        mem_addr = mem_addr_r;
        rdata0   = rdata0_r;
        rdata1   = rdata1_r;
        rvalid0  = rvalid0_r;
        rvalid1  = rvalid1_r;
    end

endmodule
